l2_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write). It sits between both L1 memory interfaces and the L2 L1-side port, grants one requester at a time with round-robin fairness, and steers address, write data, ready and read data. It also keeps grant and conflict counters for performance measurement.

---
 rtl/l2_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 23 ++
 rtl/l2_port_arbiter.sv | 135 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and constants for the L2 port arbiter
package l2_arb_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 32;

    // Grant-side encoding, also used as the bit index into req/grant vectors.
    localparam logic GSEL_I = 1'b0;
    localparam logic GSEL_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin picker
// Ports: req[1:0] (bit0 = I, bit1 = D), last (side granted last),
//        grant[1:0] one-hot pick, conflict (both requesting).
module rr_pick2
    import l2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       conflict
);

    assign conflict = &req;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        grant = req;
        if (conflict) begin
            grant = (last == GSEL_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - round-robin arbiter sharing the L2 port between I- and D-cache
// Ports: clk/reset (sync, active-high); i_mem_* I-cache read side; d_mem_* D-cache
//        read/write side; L2_* shared L2 port; *_cnt performance counters.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = l2_arb_pkg::ADDR_W,
    parameter int DATA_W = l2_arb_pkg::DATA_W,
    parameter int CNT_W  = l2_arb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              L2_read,
    output logic              L2_write,
    output logic [ADDR_W-1:0] L2_addr,
    output logic [DATA_W-1:0] L2_wdata,
    input  logic [DATA_W-1:0] L2_rdata,
    input  logic              L2_ready,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic       i_req, d_req;
    logic [1:0] pick_grant;
    logic       pick_conflict;
    logic       i_done, d_done;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    assign i_mem_rdata = L2_rdata;
    assign d_mem_rdata = L2_rdata;

    rr_pick2 u_pick (
        .req      ({d_req, i_req}),
        .last     (last_grant),
        .grant    (pick_grant),
        .conflict (pick_conflict)
    );

    // L2 request outputs depend only on state and requester inputs; L2_ready
    // feeds only the ready strobes and the next-state decision.
    always_comb begin
        state_nxt   = state;
        L2_read     = 1'b0;
        L2_write    = 1'b0;
        L2_addr     = '0;
        L2_wdata    = '0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_grant[GSEL_I]) begin
                    state_nxt = GNT_I;
                end else if (pick_grant[GSEL_D]) begin
                    state_nxt = GNT_D;
                end
            end
            GNT_I: begin
                L2_read     = i_mem_read;
                L2_addr     = i_mem_addr;
                i_mem_ready = L2_ready & i_req;
                if (!i_req) begin
                    state_nxt = IDLE;          // withdrawn: abort, nothing recorded
                end else if (L2_ready) begin
                    state_nxt = IDLE;
                    i_done    = 1'b1;
                end
            end
            GNT_D: begin
                L2_read     = d_mem_read;
                L2_write    = d_mem_write;
                L2_addr     = d_mem_addr;
                L2_wdata    = d_mem_wdata;
                d_mem_ready = L2_ready & d_req;
                if (!d_req) begin
                    state_nxt = IDLE;
                end else if (L2_ready) begin
                    state_nxt = IDLE;
                    d_done    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset is synchronous, so the state may still be a grant during the
        // reset cycle; keep the L2 port and strobes quiet regardless.
        if (reset) begin
            L2_read     = 1'b0;
            L2_write    = 1'b0;
            L2_addr     = '0;
            L2_wdata    = '0;
            i_mem_ready = 1'b0;
            d_mem_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= GSEL_D;        // I wins the first tie
            i_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (i_done) begin
                last_grant  <= GSEL_I;
                i_grant_cnt <= i_grant_cnt + CNT_W'(1);
            end
            if (d_done) begin
                last_grant  <= GSEL_D;
                d_grant_cnt <= d_grant_cnt + CNT_W'(1);
            end
            if (state == IDLE && pick_conflict) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - directed self-checking bench for l2_port_arbiter
module tb_l2_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int CW = 32;
    localparam logic [DW-1:0] RDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DW-1:0] WDATA = {16{8'hA5}};

    logic          clk = 1'b0;
    logic          reset;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_addr;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ready;
    logic          d_mem_read, d_mem_write;
    logic [AW-1:0] d_mem_addr;
    logic [DW-1:0] d_mem_wdata;
    logic [DW-1:0] d_mem_rdata;
    logic          d_mem_ready;
    logic          L2_read, L2_write;
    logic [AW-1:0] L2_addr;
    logic [DW-1:0] L2_wdata;
    logic [DW-1:0] L2_rdata;
    logic          L2_ready;
    logic [CW-1:0] i_grant_cnt, d_grant_cnt, conflict_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_mem_read   (i_mem_read),
        .i_mem_addr   (i_mem_addr),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ready  (i_mem_ready),
        .d_mem_read   (d_mem_read),
        .d_mem_write  (d_mem_write),
        .d_mem_addr   (d_mem_addr),
        .d_mem_wdata  (d_mem_wdata),
        .d_mem_rdata  (d_mem_rdata),
        .d_mem_ready  (d_mem_ready),
        .L2_read      (L2_read),
        .L2_write     (L2_write),
        .L2_addr      (L2_addr),
        .L2_wdata     (L2_wdata),
        .L2_rdata     (L2_rdata),
        .L2_ready     (L2_ready),
        .i_grant_cnt  (i_grant_cnt),
        .d_grant_cnt  (d_grant_cnt),
        .conflict_cnt (conflict_cnt)
    );

    // Drive just after the rising edge, sample on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_mem_read  = 1'b0;
        i_mem_addr  = '0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_mem_addr  = '0;
        d_mem_wdata = '0;
        L2_ready    = 1'b1;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Requests active during reset must not reach L2.
        step();
        reset = 1'b1;
        i_mem_read = 1'b1; i_mem_addr = 28'h0000111;
        d_mem_write = 1'b1; d_mem_addr = 28'h0000222; d_mem_wdata = WDATA;
        step();
        sample();
        checks++; if ({L2_read, L2_write} !== 2'b00) begin failures++; $display("FAIL reset_l2_req got=%b exp=00", {L2_read, L2_write}); end
        checks++; if (L2_addr !== '0 || L2_wdata !== '0) begin failures++; $display("FAIL reset_l2_bus addr=%h wdata=%h exp=0", L2_addr, L2_wdata); end
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {i_mem_ready, d_mem_ready}); end
        checks++; if (i_grant_cnt !== 0 || d_grant_cnt !== 0 || conflict_cnt !== 0) begin failures++; $display("FAIL reset_cnt i=%0d d=%0d c=%0d exp=0", i_grant_cnt, d_grant_cnt, conflict_cnt); end
        checks++; if (i_mem_rdata !== RDATA || d_mem_rdata !== RDATA) begin failures++; $display("FAIL reset_rdata i=%h d=%h exp=%h", i_mem_rdata, d_mem_rdata, RDATA); end
        step();
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_i_hit();
        do_reset();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
        sample();
        checks++; if (L2_read !== 1'b0 || i_mem_ready !== 1'b0) begin failures++; $display("FAIL ihit_idle rd=%b rdy=%b exp=0 0", L2_read, i_mem_ready); end
        step(); sample();
        checks++; if (L2_read !== 1'b1 || L2_addr !== 28'h0000010) begin failures++; $display("FAIL ihit_l2 rd=%b addr=%h exp=1 0000010", L2_read, L2_addr); end
        checks++; if (i_mem_ready !== 1'b1 || d_mem_ready !== 1'b0) begin failures++; $display("FAIL ihit_ready i=%b d=%b exp=1 0", i_mem_ready, d_mem_ready); end
        checks++; if (i_mem_rdata !== RDATA) begin failures++; $display("FAIL ihit_rdata got=%h exp=%h", i_mem_rdata, RDATA); end
        step(); i_mem_read = 1'b0; sample();
        checks++; if (i_grant_cnt !== 1 || L2_read !== 1'b0) begin failures++; $display("FAIL ihit_done cnt=%0d rd=%b exp=1 0", i_grant_cnt, L2_read); end
    endtask

    task automatic test_conflict();
        do_reset();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000020;
        d_mem_write = 1'b1; d_mem_addr = 28'h0000040; d_mem_wdata = WDATA;
        step(); sample();
        checks++; if ({L2_read, L2_write} !== 2'b10 || L2_addr !== 28'h0000020 || L2_wdata !== '0) begin failures++; $display("FAIL conf_gnt_i rw=%b addr=%h wdata=%h exp=10 0000020 0", {L2_read, L2_write}, L2_addr, L2_wdata); end
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b10) begin failures++; $display("FAIL conf_ready_i got=%b exp=10", {i_mem_ready, d_mem_ready}); end
        step(); i_mem_read = 1'b0; sample();
        checks++; if ({L2_read, L2_write} !== 2'b00 || L2_wdata !== '0) begin failures++; $display("FAIL conf_idle rw=%b wdata=%h exp=00 0", {L2_read, L2_write}, L2_wdata); end
        checks++; if (conflict_cnt !== 1) begin failures++; $display("FAIL conf_cnt got=%0d exp=1", conflict_cnt); end
        step(); sample();
        checks++; if ({L2_read, L2_write} !== 2'b01 || L2_addr !== 28'h0000040 || L2_wdata !== WDATA) begin failures++; $display("FAIL conf_gnt_d rw=%b addr=%h wdata=%h", {L2_read, L2_write}, L2_addr, L2_wdata); end
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b01) begin failures++; $display("FAIL conf_ready_d got=%b exp=01", {i_mem_ready, d_mem_ready}); end
        step(); d_mem_write = 1'b0; sample();
        checks++; if (i_grant_cnt !== 1 || d_grant_cnt !== 1 || conflict_cnt !== 1) begin failures++; $display("FAIL conf_final i=%0d d=%0d c=%0d exp=1 1 1", i_grant_cnt, d_grant_cnt, conflict_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000100;
        d_mem_read = 1'b1; d_mem_addr = 28'h0000200;
        for (int c = 0; c < 16; c++) begin
            logic [1:0] exp_rdy;
            if (c > 0) step();
            sample();
            if (c % 2 == 0) exp_rdy = 2'b00;
            else exp_rdy = ((c / 2) % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if ({i_mem_ready, d_mem_ready} !== exp_rdy) begin failures++; $display("FAIL b2b_cycle%0d ready(i,d)=%b exp=%b", c, {i_mem_ready, d_mem_ready}, exp_rdy); end
        end
        step(); i_mem_read = 1'b0; d_mem_read = 1'b0; sample();
        checks++; if (i_grant_cnt !== 4 || d_grant_cnt !== 4) begin failures++; $display("FAIL b2b_cnt i=%0d d=%0d exp=4 4", i_grant_cnt, d_grant_cnt); end
        checks++; if (conflict_cnt !== 8) begin failures++; $display("FAIL b2b_conflict got=%0d exp=8", conflict_cnt); end
    endtask

    task automatic test_miss();
        int d_pulses = 0;
        int bad_hold = 0;
        do_reset();
        d_mem_read = 1'b1; d_mem_addr = 28'h0000123;
        step();
        L2_ready = 1'b0;
        i_mem_read = 1'b1; i_mem_addr = 28'h0000456;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) step();
            sample();
            if (L2_read !== 1'b1 || L2_write !== 1'b0 || L2_addr !== 28'h0000123 || i_mem_ready !== 1'b0) bad_hold++;
            if (d_mem_ready === 1'b1) d_pulses++;
        end
        checks++; if (bad_hold !== 0) begin failures++; $display("FAIL miss_hold bad_cycles=%0d exp=0", bad_hold); end
        step(); L2_ready = 1'b1; sample();
        if (d_mem_ready === 1'b1) d_pulses++;
        step(); d_mem_read = 1'b0; sample();
        if (d_mem_ready === 1'b1) d_pulses++;
        checks++; if (d_pulses !== 1) begin failures++; $display("FAIL miss_dready_pulses got=%0d exp=1", d_pulses); end
        step(); sample();
        checks++; if (i_mem_ready !== 1'b1 || L2_addr !== 28'h0000456) begin failures++; $display("FAIL miss_i_after rdy=%b addr=%h exp=1 0000456", i_mem_ready, L2_addr); end
        step(); i_mem_read = 1'b0; sample();
        checks++; if (d_grant_cnt !== 1 || i_grant_cnt !== 1 || conflict_cnt !== 0) begin failures++; $display("FAIL miss_cnt i=%0d d=%0d c=%0d exp=1 1 0", i_grant_cnt, d_grant_cnt, conflict_cnt); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
        step(); step(); i_mem_read = 1'b0;
        d_mem_write = 1'b1; d_mem_addr = 28'h0000080; d_mem_wdata = WDATA;
        step(); L2_ready = 1'b0; sample();
        checks++; if (L2_write !== 1'b1 || i_grant_cnt !== 1) begin failures++; $display("FAIL rmid_pre wr=%b icnt=%0d exp=1 1", L2_write, i_grant_cnt); end
        step(); reset = 1'b1; sample();
        checks++; if ({L2_read, L2_write} !== 2'b00 || d_mem_ready !== 1'b0) begin failures++; $display("FAIL rmid_during rw=%b rdy=%b exp=00 0", {L2_read, L2_write}, d_mem_ready); end
        step(); reset = 1'b0; L2_ready = 1'b1; sample();
        checks++; if ({L2_read, L2_write} !== 2'b00 || d_mem_ready !== 1'b0) begin failures++; $display("FAIL rmid_idle rw=%b rdy=%b exp=00 0", {L2_read, L2_write}, d_mem_ready); end
        checks++; if (i_grant_cnt !== 0 || d_grant_cnt !== 0 || conflict_cnt !== 0) begin failures++; $display("FAIL rmid_cnt i=%0d d=%0d c=%0d exp=0", i_grant_cnt, d_grant_cnt, conflict_cnt); end
        step(); d_mem_write = 1'b0;
        step(); step(); sample();
        checks++; if (d_grant_cnt !== 0) begin failures++; $display("FAIL rmid_dcnt got=%0d exp=0", d_grant_cnt); end
    endtask

    task automatic test_withdraw();
        do_reset();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000300;
        step(); L2_ready = 1'b0; sample();
        checks++; if (L2_read !== 1'b1 || i_mem_ready !== 1'b0) begin failures++; $display("FAIL wd_gnt rd=%b rdy=%b exp=1 0", L2_read, i_mem_ready); end
        step(); i_mem_read = 1'b0; sample();
        checks++; if (L2_read !== 1'b0 || i_mem_ready !== 1'b0) begin failures++; $display("FAIL wd_drop rd=%b rdy=%b exp=0 0", L2_read, i_mem_ready); end
        step(); L2_ready = 1'b1;
        i_mem_read = 1'b1; i_mem_addr = 28'h0000310;
        d_mem_read = 1'b1; d_mem_addr = 28'h0000320;
        sample();
        checks++; if (i_grant_cnt !== 0) begin failures++; $display("FAIL wd_cnt got=%0d exp=0", i_grant_cnt); end
        step(); sample();
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b10 || L2_addr !== 28'h0000310) begin failures++; $display("FAIL wd_tie ready=%b addr=%h exp=10 0000310", {i_mem_ready, d_mem_ready}, L2_addr); end
        step(); i_mem_read = 1'b0; sample();
        step(); sample();
        checks++; if (d_mem_ready !== 1'b1) begin failures++; $display("FAIL wd_d_next got=%b exp=1", d_mem_ready); end
        step(); d_mem_read = 1'b0; sample();
        checks++; if (i_grant_cnt !== 1 || d_grant_cnt !== 1) begin failures++; $display("FAIL wd_final i=%0d d=%0d exp=1 1", i_grant_cnt, d_grant_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        L2_rdata = RDATA;
        idle_inputs();
        test_reset();
        test_i_hit();
        test_conflict();
        test_back_to_back();
        test_miss();
        test_reset_mid_grant();
        test_withdraw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
